// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract controller.
// The requester drives START and operands; the controller returns status and result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic             SUB;
   logic             CIN;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] SUM;
   logic             COUT;
   logic             OVF;

   modport master (
      output START, SUB, CIN, A, B,
      input  BUSY, DONE, SUM, COUT, OVF
   );

   modport slave (
      input  START, SUB, CIN, A, B,
      output BUSY, DONE, SUM, COUT, OVF
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell reused LSB first, one bit per clock,
// with registered carry, result shift register and a one-cycle DONE pulse.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input logic                CLK,
   input logic                RSTn,
   serial_adder_ctrl_if.slave bus
);
   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   // The single time-shared full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
      logic s;
      logic co;
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
      return {co, s};
   endfunction

   assign {fa_co, fa_s} = full_adder(sa_q[0], sb_q[0], c_q);
   assign last_bit      = (k_q == K_LAST);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      c_d     = c_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_RUN: begin
            sa_d = sa_q >> 1;
            sb_d = sb_q >> 1;
            sr_d = {fa_s, sr_q[WIDTH-1:1]};
            c_d  = fa_co;
            if (last_bit) begin
               // c_q here is the carry into the MSB, so overflow needs no extra register.
               state_d = S_DONE;
               sum_d   = {fa_s, sr_q[WIDTH-1:1]};
               cout_d  = fa_co;
               ovf_d   = c_q ^ fa_co;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            if (bus.START) begin
               state_d = S_RUN;
               sa_d    = bus.A;
               sb_d    = bus.SUB ? ~bus.B : bus.B;
               c_d     = bus.SUB ? 1'b1 : bus.CIN;
               k_d     = '0;
            end
         end
      endcase
   end

   // Control and visible result registers: cleared by reset.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Operand and partial-result shift registers: always reloaded before use.
   always_ff @(posedge CLK) begin
      sa_q <= sa_d;
      sb_q <= sb_d;
      sr_q <= sr_d;
   end

   assign bus.BUSY = (state_q == S_RUN);
   assign bus.DONE = (state_q == S_DONE);
   assign bus.SUM  = sum_q;
   assign bus.COUT = cout_q;
   assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 with hand-computed expected results.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic CLK;
   logic RSTn;
   int   n_checks;
   int   n_fail;
   int   done_seen;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic start, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      bus.START = start;
      bus.A     = a;
      bus.B     = b;
      bus.CIN   = cin;
      bus.SUB   = sub;
   endtask

   // One full operation from IDLE: accept, RUN for W cycles, DONE pulse, back to idle.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
      drive(1'b1, a, b, cin, sub);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check({tag, ".busy_e0"}, 32'(bus.BUSY), 32'd1);
      repeat (W - 1) tick();
      check({tag, ".busy_e7"}, 32'(bus.BUSY), 32'd1);
      check({tag, ".done_e7"}, 32'(bus.DONE), 32'd0);
      tick();
      check({tag, ".done_e8"}, 32'(bus.DONE), 32'd1);
      check({tag, ".busy_e8"}, 32'(bus.BUSY), 32'd0);
      check({tag, ".sum"},     32'(bus.SUM),  32'(exp_sum));
      check({tag, ".cout"},    32'(bus.COUT), 32'(exp_cout));
      check({tag, ".ovf"},     32'(bus.OVF),  32'(exp_ovf));
      tick();
      check({tag, ".done_e9"}, 32'(bus.DONE), 32'd0);
      check({tag, ".hold"},    32'(bus.SUM),  32'(exp_sum));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      done_seen = 0;
      RSTn      = 1'b0;
      drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);

      // Reset held two cycles with START high.
      tick();
      check("rst.busy1", 32'(bus.BUSY), 32'd0);
      tick();
      check("rst.busy", 32'(bus.BUSY), 32'd0);
      check("rst.done", 32'(bus.DONE), 32'd0);
      check("rst.sum",  32'(bus.SUM),  32'h0);
      check("rst.cout", 32'(bus.COUT), 32'd0);
      check("rst.ovf",  32'(bus.OVF),  32'd0);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      RSTn = 1'b1;
      tick();
      check("idle.busy", 32'(bus.BUSY), 32'd0);

      run_op("add5A3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
      run_op("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("addFFFFc", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("sub1020", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
      run_op("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // START during RUN ignored; START held in DONE cycle issues back-to-back.
      drive(1'b1, 8'h22, 8'h11, 1'b0, 1'b0);
      tick();                                    // e0
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      tick();                                    // e2
      drive(1'b1, 8'h77, 8'h77, 1'b1, 1'b1);
      tick();                                    // e3 edge sees START while busy
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      check("hs.busy_e3", 32'(bus.BUSY), 32'd1);
      repeat (4) tick();                         // e7
      drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
      tick();                                    // e8
      check("hs.done1", 32'(bus.DONE), 32'd1);
      check("hs.sum1",  32'(bus.SUM),  32'h33);
      check("hs.cout1", 32'(bus.COUT), 32'd0);
      tick();                                    // e9 accepts second op
      drive(1'b0, 8'hEE, 8'hEE, 1'b1, 1'b1);
      check("hs.busy_e9", 32'(bus.BUSY), 32'd1);
      check("hs.done_e9", 32'(bus.DONE), 32'd0);
      repeat (7) tick();                         // e16
      check("hs.done_e16", 32'(bus.DONE), 32'd0);
      check("hs.sum_held", 32'(bus.SUM),  32'h33);
      tick();                                    // e17
      check("hs.done2", 32'(bus.DONE), 32'd1);
      check("hs.sum2",  32'(bus.SUM),  32'h03);
      check("hs.ovf2",  32'(bus.OVF),  32'd0);
      tick();
      check("hs.idle", 32'(bus.DONE), 32'd0);

      // Reset at e4 of a run aborts it and clears the result.
      drive(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
      tick();                                    // e0
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (3) tick();                         // e3
      RSTn = 1'b0;
      tick();                                    // e4
      RSTn = 1'b1;
      check("abort.busy", 32'(bus.BUSY), 32'd0);
      check("abort.sum",  32'(bus.SUM),  32'h0);
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (bus.DONE) done_seen++;
      end
      check("abort.no_done", 32'(done_seen), 32'd0);
      check("abort.sum_kept", 32'(bus.SUM), 32'h0);
      run_op("after_abort", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
